// File: rtl/load_store_unit.sv
// load_store_unit: RV32I LB/LH/LW/LBU/LHU/SB/SH/SW engine for a word-organised data memory.
// Define LSU_MISALIGN_CHECK_EN to reject misaligned accesses instead of aligning them down.
module load_store_unit #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    input  logic [31:0] mem_data_in
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
    state_t      state_q, state_d;
    logic        live_q;
    logic        we_q, we_d, err_q, err_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, word_q, word_d;
    logic        accept, req_err, bad_f3, out_of_range, misaligned;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val, merged;

    always_comb begin
        bad_f3 = req_we ? (req_funct3 >= 3'd3) : (req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11);
        out_of_range = req_addr[31:2] >= 30'(DEPTH_WORDS);
`ifdef LSU_MISALIGN_CHECK_EN
        misaligned = (req_funct3[1:0] == 2'd1 && req_addr[0]) || (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0);
`else
        misaligned = 1'b0;
`endif
        req_err = bad_f3 || out_of_range || misaligned;
    end

    // live_q keeps req_ready low until the first clock edge after reset releases
    assign req_ready = live_q && state_q == IDLE;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        word_d  = word_q;
        case (state_q)
            IDLE: if (accept) begin
                we_d    = req_we;
                f3_d    = req_funct3;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                err_d   = req_err;
                state_d = req_err ? RESP : (!req_we || req_funct3 != 3'd2) ? READ : WRITE;
            end
            READ: begin
                word_d  = mem_data_in;
                state_d = we_q ? WRITE : RESP;
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            live_q  <= 1'b0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            word_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        byte_sel = word_q[{addr_q[1:0], 3'b000} +: 8];
        half_sel = addr_q[1] ? word_q[31:16] : word_q[15:0];
        load_val = f3_q == 3'd0 ? {{24{byte_sel[7]}}, byte_sel} :
                   f3_q == 3'd1 ? {{16{half_sel[15]}}, half_sel} :
                   f3_q == 3'd4 ? {24'd0, byte_sel} :
                   f3_q == 3'd5 ? {16'd0, half_sel} : word_q;
        merged = word_q;
        if (f3_q[0])
            merged = addr_q[1] ? {wdata_q[15:0], word_q[15:0]} : {word_q[31:16], wdata_q[15:0]};
        else
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end

    assign rsp_valid   = state_q == RESP;
    assign rsp_err     = rsp_valid && err_q;
    assign rsp_rdata   = (rsp_valid && !err_q && !we_q) ? load_val : 32'd0;
    assign mem_rd      = state_q == READ;
    assign mem_wr      = state_q == WRITE;
    assign mem_addr    = state_q != IDLE ? {2'b00, addr_q[31:2]} : 32'd0;
    assign mem_wr_data = mem_wr ? (f3_q == 3'd2 ? wdata_q : merged) : 32'd0;
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DEPTH_WORDS, default 64: number of 32-bit words in the attached data memory; legal word index is 0..DEPTH_WORDS-1.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  pipeline presents a load/store request.
REQ-005 req_ready  out  1  unit can accept a request; high only in IDLE.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_funct3  in  3  RV32I width code (LB 0, LH 1, LW 2, LBU 4, LHU 5; SB 0, SH 1, SW 2).
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data, right-aligned.
REQ-010 rsp_valid  out  1  response available.
REQ-011 rsp_ready  in  1  pipeline consumes the response.
REQ-012 rsp_rdata  out  32  load result, sign- or zero-extended; 0 for stores and errors.
REQ-013 rsp_err  out  1  request rejected (bad funct3, misaligned, or out of range).
REQ-014 mem_rd  out  1  memory read enable; memory returns data combinationally in the same cycle.
REQ-015 mem_wr  out  1  memory write enable; memory writes on the posedge.
REQ-016 mem_addr  out  32  word index = captured req_addr[31:2]; 0 when idle.
REQ-017 mem_wr_data  out  32  full word to write; 0 when mem_wr is low.
REQ-018 mem_data_in  in  32  read data from memory.

Function
REQ-019 States: IDLE, READ, WRITE, RESP.
REQ-020 In IDLE, req_valid&&req_ready captures we/funct3/addr/wdata.
REQ-021 Transitions from IDLE on accept:
- error -> RESP
- load or SB/SH -> READ
- SW -> WRITE
REQ-022 READ asserts mem_rd for exactly one cycle and registers mem_data_in at its end.
- Load: READ -> RESP.
- SB/SH: READ -> WRITE.
REQ-023 WRITE asserts mem_wr for exactly one cycle, then goes to RESP.
- SW: mem_wr_data = req_wdata.
- SB: registered word with byte addr[1:0] replaced by wdata[7:0].
- SH: registered word with halfword addr[1] replaced by wdata[15:0].
REQ-024 Load extraction selects byte addr[1:0] or halfword addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word.
REQ-025 RESP holds rsp_valid=1 with stable rsp_rdata/rsp_err until rsp_ready=1, then returns to IDLE; rsp_valid is 0 in all other states.
REQ-026 Latency from accept edge to rsp_valid (rsp_ready tied high): load 2 cycles, SW 2, SB/SH 3, error 1.
REQ-027 Throughput: one request per response; the next accept is at the earliest on the cycle after the rsp_valid&&rsp_ready cycle.
REQ-028 Error conditions:
- Load funct3 in {3,6,7}.
- Store funct3 >= 3.
- Word index >= DEPTH_WORDS.
- Misalignment, subject to REQ-033.
REQ-029 On an error, mem_rd and mem_wr never assert for that request.
REQ-030 mem_rd and mem_wr are never high in the same cycle.

Reset
REQ-031 While reset is low, independent of clk:
- state = IDLE
- req_ready = 0
- rsp_valid, rsp_err, mem_rd, mem_wr = 0
- rsp_rdata, mem_addr, mem_wr_data = 0
- all capture registers cleared
REQ-032 Reset asserted mid-operation, including in WRITE, aborts the request: mem_wr drops immediately, no write or response is issued, and req_ready rises on the first posedge after reset deasserts.

Configuration
REQ-033 Macro LSU_MISALIGN_CHECK_EN:
- Defined: LH/LHU/SH with addr[0]=1, and LW/SW with addr[1:0]!=0, are errors (REQ-028).
- Undefined: misalignment is not checked. The access uses addr aligned down to its natural width (halfword addr[0] ignored, word addr[1:0] ignored) and completes normally with rsp_err=0.

Verification
REQ-034 Memory word 3 = 0x80FF_1234; LB addr 0x0E -> rsp_rdata 0xFFFF_FFFF; LBU addr 0x0F -> 0x0000_0080; LH addr 0x0E -> 0xFFFF_80FF; latency 2.
REQ-035 SB 0xAB to addr 0x0D with word 3 = 0x80FF_1234 -> exactly one mem_rd, then one mem_wr with mem_wr_data 0x80FF_AB34; rsp_valid 3 cycles after accept.
REQ-036 SW 0xDEAD_BEEF to addr 0x100 (word 64, DEPTH_WORDS=64) -> rsp_err=1, rsp_rdata=0, no mem_rd/mem_wr, rsp_valid 1 cycle after accept.
REQ-037 LW addr 0x06:
- With LSU_MISALIGN_CHECK_EN: rsp_err=1.
- Without it: reads word 1, rsp_err=0.
REQ-038 rsp_ready held low 5 cycles during an LW response -> rsp_valid/rsp_rdata stable, req_ready=0 throughout; accept possible the cycle after the handshake.
REQ-039 Reset pulled low during WRITE of an SH -> mem_wr falls without a clock edge, no rsp_valid, target word unchanged; req_ready=1 after the first post-reset edge.
